// File: rtl/flash_sample_streamer.sv
// Streams SAMPLE_W-bit slices of flash words, one per sample-rate tick, with a one-word prefetch,
// loop/stop at the end of an address range, reverse playback and underrun detection.
module flash_sample_streamer #(
  parameter int WORD_W   = 32,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 23
) (
  input  logic                CLK_50M,
  input  logic                reset_n,
  input  logic                clock_22kHz,
  input  logic                play,
  input  logic                stop,
  input  logic                reverse,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_addr,
  input  logic                flash_valid,
  input  logic [WORD_W-1:0]   flash_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                finished,
  output logic                underrun
);

  localparam int SPW = WORD_W / SAMPLE_W;
  localparam int IW  = $clog2(SPW);
  localparam logic [IW-1:0] IDX_LAST = IW'(SPW - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state;
  logic              sync1, sync2, sync3;
  logic              dir;
  logic [ADDR_W-1:0] lo, hi, addr;
  logic              exhausted, rd_end, bad_seen;
  logic [WORD_W-1:0] cur_word, nxt_word;
  logic              cur_end, cur_empty, nxt_full, nxt_end, fin_pend;
  logic [IW-1:0]     idx;

  logic              tick, cap, at_end, issue, htick, eff_ok, eff_end, last_slice;
  logic [ADDR_W-1:0] range_start, range_end, step_addr;
  logic [WORD_W-1:0] eff_word;
  logic [IW-1:0]     sel;
  logic [SAMPLE_W-1:0] slice;

  always_comb begin
    tick        = sync2 & ~sync3;
    cap         = flash_read & flash_valid;
    range_start = dir ? hi : lo;
    range_end   = dir ? lo : hi;
    at_end      = (addr == range_end);
    if (at_end)   step_addr = range_start;
    else if (dir) step_addr = addr - ADDR_W'(1);
    else          step_addr = addr + ADDR_W'(1);
    issue = !flash_read && !stop &&
            ((state == FILL) || (state == PLAY && !nxt_full && !exhausted && !fin_pend));
    htick = tick && play && !fin_pend && !stop && (state == PLAY);
    // A word landing while cur_word is empty is played straight from the bus.
    eff_ok     = !cur_empty || cap;
    eff_word   = cur_empty ? flash_data : cur_word;
    eff_end    = cur_empty ? rd_end : cur_end;
    last_slice = (idx == IDX_LAST);
    sel        = dir ? (IDX_LAST - idx) : idx;
    slice      = '0;
    for (int i = 0; i < SPW; i++) begin
      if (sel == IW'(i)) slice = eff_word[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      dir          <= 1'b0;
      lo           <= '0;
      hi           <= '0;
      addr         <= '0;
      exhausted    <= 1'b0;
      rd_end       <= 1'b0;
      bad_seen     <= 1'b0;
      cur_word     <= '0;
      nxt_word     <= '0;
      cur_end      <= 1'b0;
      cur_empty    <= 1'b0;
      nxt_full     <= 1'b0;
      nxt_end      <= 1'b0;
      fin_pend     <= 1'b0;
      idx          <= '0;
      flash_read   <= 1'b0;
      flash_addr   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      finished     <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sync1        <= clock_22kHz;
      sync2        <= sync1;
      sync3        <= sync2;
      sample_valid <= 1'b0;
      finished     <= 1'b0;

      if (cap) flash_read <= 1'b0;
      if (issue) begin
        flash_read <= 1'b1;
        flash_addr <= addr;
        addr       <= step_addr;
        rd_end     <= at_end;
        if (at_end && !loop) exhausted <= 1'b1;
      end

      if (state != IDLE && stop) begin
        nxt_full  <= 1'b0;
        cur_empty <= 1'b0;
        fin_pend  <= 1'b0;
        state     <= (flash_read && !flash_valid) ? DRAIN : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              if (start_addr > end_addr) begin
                if (!bad_seen) finished <= 1'b1;
                bad_seen <= 1'b1;
              end else begin
                bad_seen  <= 1'b0;
                dir       <= reverse;
                lo        <= start_addr;
                hi        <= end_addr;
                addr      <= reverse ? end_addr : start_addr;
                underrun  <= 1'b0;
                exhausted <= 1'b0;
                nxt_full  <= 1'b0;
                cur_empty <= 1'b0;
                fin_pend  <= 1'b0;
                state     <= FILL;
              end
            end else begin
              bad_seen <= 1'b0;
            end
          end
          FILL: begin
            if (cap) begin
              cur_word <= flash_data;
              cur_end  <= rd_end;
              idx      <= '0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (fin_pend) begin
              finished <= 1'b1;
              fin_pend <= 1'b0;
              nxt_full <= 1'b0;
              state    <= IDLE;
            end else begin
              if (cap && !cur_empty) begin
                nxt_word <= flash_data;
                nxt_end  <= rd_end;
                nxt_full <= 1'b1;
              end
              if (cap && cur_empty) begin
                cur_word  <= flash_data;
                cur_end   <= rd_end;
                cur_empty <= 1'b0;
                idx       <= '0;
              end
              if (htick) begin
                if (!eff_ok) begin
                  underrun <= 1'b1;
                end else begin
                  sample_out   <= slice;
                  sample_valid <= 1'b1;
                  if (!last_slice) begin
                    idx <= idx + IW'(1);
                  end else if (eff_end && !loop) begin
                    fin_pend <= 1'b1;
                  end else if (nxt_full) begin
                    cur_word <= nxt_word;
                    cur_end  <= nxt_end;
                    nxt_full <= 1'b0;
                    idx      <= '0;
                  end else if (cap) begin
                    cur_word <= flash_data;
                    cur_end  <= rd_end;
                    nxt_full <= 1'b0;
                    idx      <= '0;
                  end else begin
                    cur_empty <= 1'b1;
                    idx       <= '0;
                  end
                end
              end
            end
          end
          DRAIN: begin
            if (cap) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
